core_op_dispatcher: RTL and testbench

Command front-end for the multicore `top`. Accepts a single stream of operation commands tagged with a target core, and drives each core's `start_op`/`op_sel`/`A`/`B`/`address_in`/`data_in` lanes. Holds each lane until that core's `end_op` arrives, or until a timeout expires. Returns completed results on one round-robin-arbitrated response channel.

---
 rtl/core_op_dispatcher.sv | 202 ++++++++++++++++++++
 tb/tb_core_op_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_op_dispatcher.sv
// Command front-end for the multicore top: one FSM lane per core (issue, wait for end_op or
// timeout, hold result) plus a round-robin arbitrated response channel.
package core_op_pkg;
  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    MUL   = 3'd2,
    BAND  = 3'd3,
    BOR   = 3'd4,
    BXOR  = 3'd5,
    LOAD  = 3'd6,
    STORE = 3'd7
  } opcode;
endpackage

module core_op_dispatcher
  import core_op_pkg::*;
#(
  parameter int NUM_CORES = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_core,
  input  opcode       cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [11:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        bad_cmd,
  output logic        start_op   [NUM_CORES-1:0],
  output opcode       op_sel     [NUM_CORES-1:0],
  output logic [7:0]  A          [NUM_CORES-1:0],
  output logic [7:0]  B          [NUM_CORES-1:0],
  output logic [11:0] address_in [NUM_CORES-1:0],
  output logic [7:0]  data_in    [NUM_CORES-1:0],
  input  logic        end_op     [NUM_CORES-1:0],
  input  logic [15:0] result     [NUM_CORES-1:0],
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_core,
  output logic [15:0] resp_result,
  output logic        resp_err
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} lane_state_t;

  logic [NUM_CORES-1:0] w_sel;
  logic [NUM_CORES-1:0] w_idle;
  logic [NUM_CORES-1:0] w_done;
  logic [NUM_CORES-1:0] w_lane_err;
  logic [15:0]          w_lane_res [NUM_CORES-1:0];
  logic                 w_in_range;
  logic                 w_cmd_ready;
  logic                 w_hs;
  logic [IW-1:0]        w_rr_idx;
  logic [IW-1:0]        w_grant;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_lock_idx;
  logic                 r_lock;
  logic                 r_bad_cmd;

  // Out-of-range targets are always accepted so they can be dropped.
  assign w_in_range  = |w_sel;
  assign w_cmd_ready = !rst && (!w_in_range || |(w_sel & w_idle));
  assign cmd_ready   = w_cmd_ready;
  assign bad_cmd     = r_bad_cmd;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
    lane_state_t   r_state;
    lane_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_accept;
    logic          w_release;
    logic          w_tmo;
    logic          r_start;
    opcode         r_op;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [11:0]   r_addr;
    logic [7:0]    r_data;
    logic [15:0]   r_res;
    logic          r_err;

    assign w_sel[gi]  = (cmd_core == 2'(gi));
    assign w_idle[gi] = (r_state == S_IDLE);
    assign w_done[gi] = (r_state == S_DONE);
    assign w_accept   = cmd_valid && w_cmd_ready && w_sel[gi];
    assign w_release  = w_hs && (w_grant == IW'(gi));
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_tmo      = (w_cnt_inc == CW'(TIMEOUT));

    always_comb begin
      w_state_next = r_state;
      case (r_state)
        S_IDLE:  if (w_accept) w_state_next = S_BUSY;
        S_BUSY:  if (end_op[gi] || w_tmo) w_state_next = S_DONE;
        S_DONE:  if (w_release) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_start <= 1'b0;
        r_op    <= ADD;
        r_a     <= '0;
        r_b     <= '0;
        r_addr  <= '0;
        r_data  <= '0;
        r_cnt   <= '0;
        r_res   <= '0;
        r_err   <= 1'b0;
      end else begin
        if (r_state == S_IDLE && w_accept) begin
          r_start <= 1'b1;
          r_op    <= cmd_op;
          r_a     <= cmd_a;
          r_b     <= cmd_b;
          r_addr  <= cmd_addr;
          r_data  <= cmd_data;
          r_cnt   <= '0;
        end
        // end_op takes priority over a timeout landing on the same edge.
        if (r_state == S_BUSY) begin
          r_cnt <= w_cnt_inc;
          if (end_op[gi]) begin
            r_start <= 1'b0;
            r_res   <= result[gi];
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_start <= 1'b0;
            r_res   <= '0;
            r_err   <= 1'b1;
          end
        end
      end
    end

    assign start_op[gi]   = r_start;
    assign op_sel[gi]     = r_op;
    assign A[gi]          = r_a;
    assign B[gi]          = r_b;
    assign address_in[gi] = r_addr;
    assign data_in[gi]    = r_data;
    assign w_lane_res[gi] = r_res;
    assign w_lane_err[gi] = r_err;
  end

  // Lowest DONE lane overall, overridden by the lowest DONE lane at or above the pointer.
  always_comb begin
    w_rr_idx = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (w_done[j]) w_rr_idx = IW'(j);
    end
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (w_done[j] && j >= int'(r_ptr)) w_rr_idx = IW'(j);
    end
  end

  assign w_grant = r_lock ? r_lock_idx : w_rr_idx;

  always_comb begin
    resp_valid  = 1'b0;
    resp_core   = '0;
    resp_result = '0;
    resp_err    = 1'b0;
    if (!rst && |w_done) begin
      resp_valid  = 1'b1;
      resp_core   = 2'(w_grant);
      resp_result = w_lane_res[w_grant];
      resp_err    = w_lane_err[w_grant];
    end
  end

  assign w_hs = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_bad_cmd  <= 1'b0;
    end else begin
      r_bad_cmd  <= cmd_valid && w_cmd_ready && !w_in_range;
      r_lock     <= resp_valid && !resp_ready;
      r_lock_idx <= w_grant;
      if (w_hs) r_ptr <= (int'(w_grant) == NUM_CORES - 1) ? '0 : w_grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_op_dispatcher.sv
// Directed self-checking bench for core_op_dispatcher; cores are emulated by driving
// end_op/result by hand from each scenario task.
module tb_core_op_dispatcher;
  import core_op_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_core;
  opcode       cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        bad_cmd;
  logic        start_op   [N-1:0];
  opcode       op_sel     [N-1:0];
  logic [7:0]  A          [N-1:0];
  logic [7:0]  B          [N-1:0];
  logic [11:0] address_in [N-1:0];
  logic [7:0]  data_in    [N-1:0];
  logic        end_op     [N-1:0];
  logic [15:0] result     [N-1:0];
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_core;
  logic [15:0] resp_result;
  logic        resp_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_op_dispatcher #(.NUM_CORES(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_core(cmd_core), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bad_cmd(bad_cmd),
    .start_op(start_op), .op_sel(op_sel), .A(A), .B(B), .address_in(address_in), .data_in(data_in),
    .end_op(end_op), .result(result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_core(resp_core),
    .resp_result(resp_result), .resp_err(resp_err)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input logic [1:0] core, input opcode op, input logic [7:0] a,
                         input logic [7:0] b, input logic [11:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_core  = core;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_addr  = addr;
    cmd_data  = data;
    $display("cmd: core=%0d op=%0d a=%h b=%h addr=%h data=%h", core, op, a, b, addr, data);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_core   = 2'd0;
    cmd_op     = ADD;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_addr   = '0;
    cmd_data   = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      end_op[i] = 1'b0;
      result[i] = '0;
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    #1;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_total++; if (start_op[i] !== 1'b0) $display("FAIL rst_start_op%0d: got %0b want 0", i, start_op[i]); else n_pass++;
      n_total++; if (op_sel[i] !== ADD) $display("FAIL rst_op_sel%0d: got %0d want 0", i, op_sel[i]); else n_pass++;
      n_total++; if (A[i] !== 8'h00 || B[i] !== 8'h00) $display("FAIL rst_ab%0d: got %h/%h want 00/00", i, A[i], B[i]); else n_pass++;
    end
    n_total++; if (resp_valid !== 1'b0 || resp_result !== 16'h0 || resp_err !== 1'b0 || resp_core !== 2'd0)
      $display("FAIL rst_resp: got v=%0b c=%0d r=%h e=%0b want all 0", resp_valid, resp_core, resp_result, resp_err); else n_pass++;
    n_total++; if (bad_cmd !== 1'b0) $display("FAIL rst_bad_cmd: got %0b want 0", bad_cmd); else n_pass++;
    cmd_valid = 1'b0;
    rst       = 1'b0;
    step();
  endtask

  task automatic test_single_add();
    do_reset();
    resp_ready = 1'b1;
    set_cmd(2'd0, ADD, 8'h01, 8'h05, 12'h000, 8'h00);
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL add_cmd_ready: got %0b want 1", cmd_ready); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_total++; if (start_op[0] !== 1'b1) $display("FAIL add_start: got %0b want 1", start_op[0]); else n_pass++;
    n_total++; if (op_sel[0] !== ADD) $display("FAIL add_op_sel: got %0d want 0", op_sel[0]); else n_pass++;
    n_total++; if (A[0] !== 8'h01 || B[0] !== 8'h05) $display("FAIL add_operands: got %h/%h want 01/05", A[0], B[0]); else n_pass++;
    step();
    n_total++; if (start_op[0] !== 1'b1 || A[0] !== 8'h01) $display("FAIL add_hold: got start=%0b A=%h want 1/01", start_op[0], A[0]); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL add_early_resp: got %0b want 0", resp_valid); else n_pass++;
    end_op[0] = 1'b1;
    result[0] = 16'h0006;
    step();
    end_op[0] = 1'b0;
    n_total++; if (start_op[0] !== 1'b0) $display("FAIL add_start_drop: got %0b want 0", start_op[0]); else n_pass++;
    n_total++; if (resp_valid !== 1'b1 || resp_core !== 2'd0 || resp_result !== 16'h0006 || resp_err !== 1'b0)
      $display("FAIL add_resp: got v=%0b c=%0d r=%h e=%0b want 1/0/0006/0", resp_valid, resp_core, resp_result, resp_err); else n_pass++;
    $display("resp: core=%0d result=%h err=%0b", resp_core, resp_result, resp_err);
    step();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL add_resp_once: got %0b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_store_load();
    do_reset();
    set_cmd(2'd0, STORE, 8'h00, 8'h00, 12'h011, 8'hFE);
    step();
    set_cmd(2'd0, LOAD, 8'h00, 8'h00, 12'h011, 8'h00);
    #1;
    n_total++; if (op_sel[0] !== STORE || address_in[0] !== 12'h011 || data_in[0] !== 8'hFE)
      $display("FAIL st_lane: got op=%0d addr=%h data=%h want 7/011/fe", op_sel[0], address_in[0], data_in[0]); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL st_stall_busy: got %0b want 0", cmd_ready); else n_pass++;
    end_op[0] = 1'b1;
    result[0] = 16'h0000;
    step();
    end_op[0] = 1'b0;
    #1;
    n_total++; if (resp_valid !== 1'b1 || cmd_ready !== 1'b0)
      $display("FAIL st_stall_done: got v=%0b rdy=%0b want 1/0", resp_valid, cmd_ready); else n_pass++;
    resp_ready = 1'b1;
    step();
    n_total++; if (start_op[0] !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL st_no_same_cycle: got start=%0b v=%0b want 0/0", start_op[0], resp_valid); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL st_ready_after_hs: got %0b want 1", cmd_ready); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_total++; if (start_op[0] !== 1'b1 || op_sel[0] !== LOAD || address_in[0] !== 12'h011)
      $display("FAIL ld_issue: got start=%0b op=%0d addr=%h want 1/6/011", start_op[0], op_sel[0], address_in[0]); else n_pass++;
    end_op[0] = 1'b1;
    result[0] = 16'h00FE;
    step();
    end_op[0] = 1'b0;
    n_total++; if (resp_valid !== 1'b1 || resp_result[7:0] !== 8'hFE || resp_err !== 1'b0)
      $display("FAIL ld_resp: got v=%0b r=%h e=%0b want 1/fe/0", resp_valid, resp_result[7:0], resp_err); else n_pass++;
    $display("resp: core=%0d result=%h err=%0b", resp_core, resp_result, resp_err);
    step();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL ld_resp_once: got %0b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_parallel();
    logic [15:0] exp_res [N-1:0];
    exp_res[0] = 16'h01FD;
    exp_res[1] = 16'h0012;
    exp_res[2] = 16'h0030;
    do_reset();
    set_cmd(2'd0, ADD, 8'hFF, 8'hFE, 12'h000, 8'h00);
    step();
    set_cmd(2'd1, ADD, 8'h01, 8'h11, 12'h000, 8'h00);
    step();
    set_cmd(2'd2, ADD, 8'h10, 8'h20, 12'h000, 8'h00);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_total++; if (start_op[i] !== 1'b1) $display("FAIL par_start%0d: got %0b want 1", i, start_op[i]); else n_pass++;
    end
    n_total++; if (A[2] !== 8'h10 || B[2] !== 8'h20) $display("FAIL par_ops2: got %h/%h want 10/20", A[2], B[2]); else n_pass++;
    for (int i = 0; i < N; i++) begin
      end_op[i] = 1'b1;
      result[i] = exp_res[i];
    end
    step();
    for (int i = 0; i < N; i++) end_op[i] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_total++; if (resp_valid !== 1'b1 || resp_core !== 2'd0 || resp_result !== 16'h01FD)
        $display("FAIL par_stall%0d: got v=%0b c=%0d r=%h want 1/0/01fd", s, resp_valid, resp_core, resp_result); else n_pass++;
      if (s < 2) step();
    end
    resp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      n_total++; if (resp_valid !== 1'b1 || resp_core !== 2'(k) || resp_result !== exp_res[k] || resp_err !== 1'b0)
        $display("FAIL par_order%0d: got v=%0b c=%0d r=%h e=%0b want 1/%0d/%h/0", k, resp_valid, resp_core, resp_result, resp_err, k, exp_res[k]); else n_pass++;
      $display("resp: core=%0d result=%h err=%0b", resp_core, resp_result, resp_err);
      step();
    end
    n_total++; if (resp_valid !== 1'b0) $display("FAIL par_drain: got %0b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    set_cmd(2'd1, ADD, 8'h03, 8'h04, 12'h000, 8'h00);
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k < TMO; k++) step();
    n_total++; if (resp_valid !== 1'b0 || start_op[1] !== 1'b1)
      $display("FAIL tmo_early: got v=%0b start=%0b want 0/1", resp_valid, start_op[1]); else n_pass++;
    step();
    n_total++; if (resp_valid !== 1'b1 || resp_core !== 2'd1 || resp_err !== 1'b1 || resp_result !== 16'h0)
      $display("FAIL tmo_resp: got v=%0b c=%0d r=%h e=%0b want 1/1/0000/1", resp_valid, resp_core, resp_result, resp_err); else n_pass++;
    n_total++; if (start_op[1] !== 1'b0) $display("FAIL tmo_start_drop: got %0b want 0", start_op[1]); else n_pass++;
    $display("resp: core=%0d result=%h err=%0b", resp_core, resp_result, resp_err);
    resp_ready = 1'b1;
    step();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL tmo_drain: got %0b want 0", resp_valid); else n_pass++;
    set_cmd(2'd1, ADD, 8'h20, 8'h22, 12'h000, 8'h00);
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL tmo_reaccept: got %0b want 1", cmd_ready); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_total++; if (start_op[1] !== 1'b1) $display("FAIL tmo_reissue: got %0b want 1", start_op[1]); else n_pass++;
    for (int k = 1; k < TMO; k++) step();
    end_op[1] = 1'b1;
    result[1] = 16'h0042;
    step();
    end_op[1] = 1'b0;
    n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_result !== 16'h0042)
      $display("FAIL tmo_tie_endop: got v=%0b r=%h e=%0b want 1/0042/0", resp_valid, resp_result, resp_err); else n_pass++;
    $display("resp: core=%0d result=%h err=%0b", resp_core, resp_result, resp_err);
    step();
  endtask

  task automatic test_bad_and_reset();
    do_reset();
    set_cmd(2'd3, ADD, 8'h09, 8'h09, 12'h000, 8'h00);
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL bad_ready: got %0b want 1", cmd_ready); else n_pass++;
    step();
    cmd_valid = 1'b0;
    n_total++; if (bad_cmd !== 1'b1) $display("FAIL bad_pulse: got %0b want 1", bad_cmd); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_total++; if (start_op[i] !== 1'b0) $display("FAIL bad_no_lane%0d: got %0b want 0", i, start_op[i]); else n_pass++;
    end
    step();
    n_total++; if (bad_cmd !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL bad_one_cycle: got bad=%0b v=%0b want 0/0", bad_cmd, resp_valid); else n_pass++;
    set_cmd(2'd2, ADD, 8'h07, 8'h08, 12'h000, 8'h00);
    step();
    cmd_valid = 1'b0;
    n_total++; if (start_op[2] !== 1'b1) $display("FAIL rmid_issue: got %0b want 1", start_op[2]); else n_pass++;
    step();
    rst       = 1'b1;
    end_op[2] = 1'b1;
    result[2] = 16'h0055;
    step();
    n_total++; if (start_op[2] !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rmid_edge: got start=%0b v=%0b want 0/0", start_op[2], resp_valid); else n_pass++;
    rst       = 1'b0;
    end_op[2] = 1'b0;
    resp_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      n_total++; if (resp_valid !== 1'b0 || start_op[2] !== 1'b0)
        $display("FAIL rmid_stale%0d: got v=%0b start=%0b want 0/0", s, resp_valid, start_op[2]); else n_pass++;
    end
    set_cmd(2'd2, ADD, 8'h00, 8'h00, 12'h000, 8'h00);
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rmid_lane_idle: got %0b want 1", cmd_ready); else n_pass++;
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_store_load();
    test_parallel();
    test_timeout();
    test_bad_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
